// File: rtl/stopwatch_display.sv
// Stopwatch display back end: snapshots the binary time fields, converts them to BCD with an
// iterative double-dabble loop and scans them onto a 9-digit multiplexed active-low display.
module stopwatch_display #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter bit          BLANK_HRS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [9:0] milliseconds,
  input  logic       freeze,
  output logic [6:0] seg,
  output logic       dp,
  output logic [8:0] an,
  output logic       conv_done
);
  localparam int unsigned PW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {LOAD, CONV, COMMIT} state_t;

  state_t           state_q;
  logic [3:0]       iter_q;
  logic [3:0][9:0]  bin_q;    // field 0 ms, 1 sec, 2 min, 3 hours
  logic [3:0][11:0] bcd_q;
  logic [3:0][21:0] step_w;
  logic [8:0][3:0]  disp_q;   // digit 0 = ms units
  logic             conv_done_q;

  function automatic logic [21:0] dabble_step(input logic [11:0] bcd, input logic [9:0] bin);
    logic [11:0] adj;
    adj = bcd;
    for (int n = 0; n < 3; n++)
      if (adj[4*n +: 4] >= 4'd5) adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
    return {adj[10:0], bin, 1'b0};
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    unique case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb begin
    for (int f = 0; f < 4; f++) step_w[f] = dabble_step(bcd_q[f], bin_q[f]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      iter_q      <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      disp_q      <= '0;
      conv_done_q <= 1'b0;
    end else begin
      conv_done_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          bin_q[0] <= (milliseconds > 10'd999) ? 10'd999 : milliseconds;
          bin_q[1] <= {4'd0, seconds};
          bin_q[2] <= {4'd0, minutes};
          bin_q[3] <= {6'd0, hours};
          bcd_q    <= '0;
          iter_q   <= '0;
          state_q  <= CONV;
        end
        CONV: begin
          for (int f = 0; f < 4; f++) begin
            bcd_q[f] <= step_w[f][21:10];
            bin_q[f] <= step_w[f][9:0];
          end
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd9) state_q <= COMMIT;
        end
        COMMIT: begin
          // Lap hold: freeze only gates the commit, the conversion loop keeps running.
          if (!freeze) begin
            disp_q      <= {bcd_q[3][7:0], bcd_q[2][7:0], bcd_q[1][7:0], bcd_q[0]};
            conv_done_q <= 1'b1;
          end
          state_q <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    digit;
  logic [6:0]    seg_d, seg_q;
  logic          dp_d, dp_q;
  logic [8:0]    an_q;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
    end
    digit = disp_q[idx_q];
    seg_d = decode(digit);
    if (BLANK_HRS && idx_q == 4'd8 && digit == 4'd0) seg_d = 7'h7F;
    dp_d  = !(idx_q == 4'd3 || idx_q == 4'd5 || idx_q == 4'd7);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= 9'h1FF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= ~(9'd1 << idx_q);
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign conv_done = conv_done_q;

endmodule
